// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory-macro port of mem_port_arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store traffic.
// Optional feature: define MEM_ARB_RR_EN for round-robin instead of data-first priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       grant_d;
  logic       start;
  logic       pick_d;

  assign start = (state == IDLE) && (bus.if_req || bus.d_req);

`ifdef MEM_ARB_RR_EN
  // 1 = data was granted last; a tie goes to whichever side did not win last time.
  logic last_grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_grant_d <= 1'b1;
    else if (start) last_grant_d <= pick_d;
  end

  assign pick_d = bus.d_req && !(bus.if_req && last_grant_d);
`else
  assign pick_d = bus.d_req;
`endif

  // NOTE: all state and output registers use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      grant_d       <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.if_rdata  <= {DATA_W{1'b0}};
      bus.d_rdata   <= {DATA_W{1'b0}};
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= BUSY;
            cnt        <= LAT_LOAD;
            grant_d    <= pick_d;
            bus.mem_en <= 1'b1;
            bus.busy   <= 1'b1;
            if (pick_d) begin
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
            end else begin
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.if_addr;
              bus.mem_wdata <= {DATA_W{1'b0}};
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            // Read data is valid only on the edge that ends the last BUSY cycle.
            if (grant_d) begin
              if (!bus.mem_we) bus.d_rdata <= bus.mem_rdata;
              bus.d_ack <= 1'b1;
            end else begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_ack   <= 1'b1;
            end
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            state      <= ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          bus.if_ack <= 1'b0;
          bus.d_ack  <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
